// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit shared types: operation encoding (funct3), FSM states
// and small operation-class helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } mdu_state_t;

  function automatic logic is_div(mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic a_signed(mdu_op_t op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic b_signed(mdu_op_t op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage and
// the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  import muldiv_unit_pkg::*;

  logic            i_valid;
  logic            o_ready;
  mdu_op_t         i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_op, i_a, i_b, i_flush, i_ready,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_flush, i_ready,
    output o_ready, o_valid, o_result
  );

endinterface

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_div};

  // Top bit of the difference is the borrow: divisor did not fit
  assign o_rem = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit (shift-add / restoring).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          i_clk,
  input logic          i_rst_n,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        r_state, w_next;
  mdu_op_t           r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sa, r_sb;

  logic              w_accept, w_sa, w_sb;
  logic              w_dz, w_ovf, w_special, w_fast;
  logic [XLEN-1:0]   w_ma, w_mb, w_spec_res, w_fast_res;
  logic [XLEN:0]     w_msum;
  logic [2*XLEN-1:0] w_mstep, w_prod;
  logic [XLEN-1:0]   w_drem, w_dquo, w_dsel, w_fixres;
  logic              w_neg;

  assign w_accept = (r_state == IDLE) && bus.i_valid && !bus.i_flush;
  assign w_sa = a_signed(bus.i_op) & bus.i_a[XLEN-1];
  assign w_sb = b_signed(bus.i_op) & bus.i_b[XLEN-1];
  assign w_ma = w_sa ? -bus.i_a : bus.i_a;
  assign w_mb = w_sb ? -bus.i_b : bus.i_b;

  assign w_dz  = is_div(bus.i_op) && (bus.i_b == '0);
  assign w_ovf = (bus.i_op == DIV || bus.i_op == REM)
              && (bus.i_a == MIN_NEG) && (bus.i_b == '1);
  assign w_special = w_dz || w_ovf;

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_spec_res = '0;
    unique case (1'b1)
      w_dz:    w_spec_res = bus.i_op[1] ? bus.i_a : '1;
      w_ovf:   w_spec_res = bus.i_op[1] ? '0 : bus.i_a;
      default: w_spec_res = '0;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] w_fa, w_fb, w_fp;
  assign w_fa = {{XLEN{w_sa}}, bus.i_a};
  assign w_fb = {{XLEN{w_sb}}, bus.i_b};
  assign w_fp = w_fa * w_fb;
  assign w_fast = !is_div(bus.i_op);
  assign w_fast_res = (bus.i_op == MUL) ? w_fp[XLEN-1:0]
                                        : w_fp[2*XLEN-1:XLEN];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mstep = {w_msum, r_acc[XLEN-1:1]};

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem (r_acc[2*XLEN-1:XLEN]),
    .i_quo (r_acc[XLEN-1:0]),
    .i_div (r_opnd),
    .o_rem (w_drem),
    .o_quo (w_dquo)
  );

  assign w_neg  = (r_op == REM) ? r_sa : (r_sa ^ r_sb);
  assign w_dsel = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
  assign w_prod = w_neg ? -r_acc : r_acc;

  always_comb begin
    w_fixres = '0;
    if (is_div(r_op))
      w_fixres = w_neg ? -w_dsel : w_dsel;
    else if (r_op == MUL)
      w_fixres = w_prod[XLEN-1:0];
    else
      w_fixres = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.i_valid)
              w_next = (w_special || w_fast) ? DONE : BUSY;
      BUSY: if (r_cnt == CNT_W'(1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: if (bus.i_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.i_flush) w_next = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= MUL;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_op  <= bus.i_op;
          r_sa  <= w_sa;
          r_sb  <= w_sb;
          r_cnt <= CNT_W'(XLEN);
          // Multiplier in the low half, dividend in the quotient half
          r_acc  <= {{XLEN{1'b0}}, is_div(bus.i_op) ? w_ma : w_mb};
          r_opnd <= is_div(bus.i_op) ? w_mb : w_ma;
          if (w_special)   r_result <= w_spec_res;
          else if (w_fast) r_result <= w_fast_res;
        end
        BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          r_acc <= is_div(r_op) ? {w_drem, w_dquo} : w_mstep;
        end
        FIX:  r_result <= w_fixres;
        default: ;
      endcase
    end
  end

  assign bus.o_ready  = (r_state == IDLE);
  assign bus.o_valid  = (r_state == DONE);
  assign bus.o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): arithmetic reference
// model, per-result scoreboard, latency, backpressure, flush, reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 34;
`endif
  localparam int DLAT = 34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  muldiv_unit_if #(.XLEN(32)) bus();

  muldiv_unit #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input mdu_op_t op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (op)
      MUL:    begin p = ua * ub; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb;
        return p[31:0];
      end
      DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard: every result handshake is checked against the model
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected: got %h expected none",
                 bus.o_result);
      end else begin
        chk("result", bus.o_result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input mdu_op_t op, input logic [31:0] a,
                       input logic [31:0] b);
    chk("ready_before_issue", {31'b0, bus.o_ready}, 32'd1);
    bus.i_valid = 1'b1;
    bus.i_op = op;
    bus.i_a = a;
    bus.i_b = b;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.o_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input mdu_op_t op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit,
                     input int lat);
    logic [31:0] e;
    int n;
    e = model(op, a, b);
    chk($sformatf("model_%s", op.name()), e, lit);
    exp_q.push_back(e);
    bus.i_ready = 1'b1;
    issue(op, a, b);
    wait_valid(n);
    chk($sformatf("latency_%s", op.name()), n, lat);
    if (!bus.o_valid && exp_q.size() > 0) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    chk("idle_after_handshake", {30'b0, bus.o_valid, bus.o_ready}, 32'd1);
  endtask

  task automatic no_valid_for(input string name, input int cyc);
    logic seen;
    seen = 1'b0;
    repeat (cyc) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) seen = 1'b1;
    end
    chk(name, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    int n;
    bus.i_valid = 1'b0;
    bus.i_op = MUL;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;

    #1;
    chk("reset_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("reset_ready", {31'b0, bus.o_ready}, 32'd1);
    chk("reset_result", bus.o_result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT);
    run(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MLAT);
    run(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT);
    run(MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MLAT);
    run(MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, MLAT);
    run(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DLAT);
    run(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DLAT);
    run(DIVU,   32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, DLAT);
    run(REMU,   32'hFFFF_FFFF, 32'h10,        32'h0000_000F, DLAT);
    run(DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DLAT);
    run(REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         DLAT);
    run(DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run(REMU,   32'd5,         32'd0,         32'd5,         1);
    run(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Backpressure: result held while the consumer stalls
    e = model(DIVU, 32'd100, 32'd7);
    chk("model_bp", e, 32'd14);
    exp_q.push_back(e);
    bus.i_ready = 1'b0;
    issue(DIVU, 32'd100, 32'd7);
    wait_valid(n);
    chk("latency_bp", n, DLAT);
    repeat (5) begin
      bus.i_valid = 1'b1;
      bus.i_op = MUL;
      bus.i_a = 32'd3;
      bus.i_b = 32'd3;
      chk("bp_valid", {31'b0, bus.o_valid}, 32'd1);
      chk("bp_ready", {31'b0, bus.o_ready}, 32'd0);
      chk("bp_result", bus.o_result, e);
      @(posedge clk);
      #1;
    end
    chk("bp_result_end", bus.o_result, e);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", {30'b0, bus.o_valid, bus.o_ready}, 32'd1);
    run(REMU, 32'd100, 32'd7, 32'd2, DLAT);

    // Flush at the tenth BUSY cycle
    issue(DIV, 32'd100, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("flush_busy", {31'b0, bus.o_ready}, 32'd0);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    chk("flush_ready", {31'b0, bus.o_ready}, 32'd1);
    no_valid_for("flush_no_valid", 40);

    // Flush together with a request in IDLE: not accepted
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op = DIVU;
    bus.i_a = 32'd9;
    bus.i_b = 32'd3;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    chk("flush_idle_ready", {31'b0, bus.o_ready}, 32'd1);
    no_valid_for("flush_idle_no_valid", 40);

    // Asynchronous reset in the middle of an operation
    issue(DIVU, 32'hFFFF_FFFF, 32'd3);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("busy_before_reset", {31'b0, bus.o_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("rst_result", bus.o_result, 32'd0);
    chk("rst_ready", {31'b0, bus.o_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(DIVU, 32'd100, 32'd7, 32'd14, DLAT);
    run(MUL,  32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
